chroni_vram_arbiter: RTL
========================

CHRONI_VRAM_ARBITER -- requirements
Module: chroni_vram_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2: sys_clk edges from mem_addr issue to valid mem_rd_data (legal 1..3).
REQ-002 SHALL have parameter CPU_STARVE_MAX, default 32: pending-CPU cycles under DMA before one forced CPU slot.
REQ-003 SHALL have port sys_clk  in  1  system clock; every edge rising.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset, sampled on sys_clk.
REQ-005 SHALL have ports vid_addr in 13, vid_rd_req in 1 (level, held until ack), vid_dma_req in 1 (video priority window).
REQ-006 SHALL have ports vid_rd_ack out 1 (one-cycle pulse), vid_data out 8 (valid while vid_rd_ack=1).
REQ-007 SHALL have ports cpu_addr in 13, cpu_rd_req in 1, cpu_wr_req in 1, cpu_wr_data in 8 (all level, held until ack).
REQ-008 SHALL have ports cpu_ack out 1 (one-cycle pulse), cpu_rd_data out 8 (valid with cpu_ack on reads), cpu_wait out 1.
REQ-009 SHALL have ports mem_addr out 13, mem_wr_en out 1, mem_wr_data out 8, mem_rd_data in 8 (single-port synchronous VRAM).

Function
REQ-010 SHALL implement states IDLE, VID_RD, CPU_RD, CPU_WR, WAIT, DONE; exactly one memory access in flight.
REQ-011 IDLE SHALL sample requests each edge; grant order: forced CPU slot, then video if vid_dma_req=1, else round-robin.
REQ-012 Round-robin SHALL grant the requester not granted last when both pending; single pending requester granted immediately.
REQ-013 CPU request with both cpu_rd_req and cpu_wr_req high SHALL be treated as write.
REQ-014 Grant SHALL register mem_addr from requester address on the granting edge; video/CPU-read enter VID_RD/CPU_RD.
REQ-015 CPU_WR SHALL drive mem_wr_en=1 with mem_wr_data=cpu_wr_data for exactly one cycle, then DONE; cpu_ack asserted in DONE.
REQ-016 Reads SHALL count MEM_LATENCY cycles (2-bit counter, in WAIT), capture mem_rd_data into vid_data or cpu_rd_data, then DONE.
REQ-017 Read latency request-sampled to ack SHALL be MEM_LATENCY+2 cycles; write latency SHALL be 2 cycles.
REQ-018 DONE SHALL last exactly one cycle, pulse the matching ack, and return to IDLE without sampling requests (requester drops req on ack edge).
REQ-019 vid_data/cpu_rd_data SHALL hold last captured value until next read of same requester.
REQ-020 mem_wr_en SHALL be 0 in every state except CPU_WR.
REQ-021 cpu_wait SHALL be 1 whenever a CPU request is pending and not in DONE for that request; 0 otherwise.
REQ-022 Starvation counter (6 bits, saturating) SHALL increment each cycle CPU pending, vid_dma_req=1, CPU not granted; clear on CPU grant or no CPU request.
REQ-023 Counter reaching CPU_STARVE_MAX SHALL force next IDLE grant to CPU, then counter clears.
REQ-024 Requests deasserted mid-access SHALL NOT abort; access completes and ack still pulses.
REQ-025 vid_dma_req falling mid-access SHALL NOT affect current access; affects only next arbitration.
REQ-026 Address values SHALL pass unmodified; no wrap or increment inside block.

Reset
REQ-027 reset_n=0 at an edge SHALL force IDLE, abort any access, round-robin pointer to CPU-last, starvation counter 0.
REQ-028 During and after reset: vid_rd_ack=0, cpu_ack=0, cpu_wait=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, vid_data=0, cpu_rd_data=0.
REQ-029 Aborted access SHALL produce no ack after reset release; requesters re-request.

Verification
REQ-030 Video read: vid_rd_req=1, vid_addr=0x1E00, mem returns 0x41 -> vid_rd_ack one pulse at cycle 4, vid_data=0x41, no cpu_ack.
REQ-031 CPU write then read: wr 0x0123<=0x5A -> mem_wr_en one cycle, cpu_ack cycle 2; read 0x0123 -> cpu_rd_data=0x5A, cpu_ack cycle 4.
REQ-032 Contention, vid_dma_req=0, both pending continuously -> grants alternate CPU/video; each ack exactly once per access.
REQ-033 Starvation: vid_dma_req=1, video back-to-back, CPU read pending -> CPU granted once counter hits 32; cpu_wait=1 until its cpu_ack.
REQ-034 Reset mid-read (during WAIT) -> all outputs 0 next cycle, no ack emitted, fresh request afterwards completes normally.

Source files
------------

// File: rtl/chroni_vram_arbiter.sv
// -----------------------------------------------------------------------------
// chroni_vram_arbiter
//
// Shares one single-port synchronous VRAM between the video fetch engine and
// the CPU. Exactly one memory access is in flight at a time. Video gets the
// bus while its DMA window is open, otherwise the two requesters alternate.
// A CPU that is kept waiting by video DMA for too long gets a forced slot.
//
// Ports:
//   sys_clk, reset_n        clock, synchronous active-low reset
//   vid_addr/vid_rd_req     video read request (level, held until ack)
//   vid_dma_req             video priority window
//   vid_rd_ack/vid_data     one-cycle ack pulse, read data (held until next)
//   cpu_addr/cpu_rd_req/    CPU read/write request (level, held until ack);
//   cpu_wr_req/cpu_wr_data  read+write together is treated as a write
//   cpu_ack/cpu_rd_data     one-cycle ack pulse, read data (held until next)
//   cpu_wait                CPU request pending and not yet being acked
//   mem_addr/mem_wr_en/     VRAM address, write strobe, write data,
//   mem_wr_data/mem_rd_data read data (valid MEM_LATENCY edges after addr)
//
// Parameters:
//   MEM_LATENCY     VRAM read latency in sys_clk edges, 1..3
//   CPU_STARVE_MAX  CPU-pending cycles under DMA before a forced CPU slot, 1..63
// -----------------------------------------------------------------------------
module chroni_vram_arbiter #(
  parameter int MEM_LATENCY    = 2,
  parameter int CPU_STARVE_MAX = 32
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [12:0] vid_addr,
  input  logic        vid_rd_req,
  input  logic        vid_dma_req,
  output logic        vid_rd_ack,
  output logic [7:0]  vid_data,
  input  logic [12:0] cpu_addr,
  input  logic        cpu_rd_req,
  input  logic        cpu_wr_req,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_wait,
  output logic [12:0] mem_addr,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    VID_RD,
    CPU_RD,
    CPU_WR,
    WAIT,
    DONE
  } state_t;

  // Last WAIT count value: data is captured when the counter reaches it.
  localparam logic [1:0] LAT_LAST     = 2'(MEM_LATENCY - 1);
  localparam logic [5:0] STARVE_LIMIT = 6'(CPU_STARVE_MAX);

  state_t      state;
  logic [1:0]  lat_cnt;
  logic        owner_cpu;
  logic        last_cpu;
  logic [5:0]  starve_cnt;

  logic        cpu_pending;
  logic        starve_hit;
  logic        grant_cpu;
  logic        grant_vid;
  logic        cpu_active;

  assign cpu_pending = cpu_rd_req | cpu_wr_req;
  assign starve_hit  = (starve_cnt >= STARVE_LIMIT);

  // Grant order: forced CPU slot, then video inside its DMA window, then
  // round-robin (the side not served last wins a tie).
  assign grant_cpu = (state == IDLE) && cpu_pending &&
                     (starve_hit || !vid_rd_req || (!vid_dma_req && !last_cpu));
  assign grant_vid = (state == IDLE) && vid_rd_req && !grant_cpu;

  // The CPU counts as granted for the whole of its own access, so the
  // starvation counter does not creep up while the CPU is being served.
  assign cpu_active = (state == CPU_RD) || (state == CPU_WR) ||
                      (((state == WAIT) || (state == DONE)) && owner_cpu);

  // cpu_ack is only ever high in DONE for a CPU access, so it marks the one
  // cycle where a pending CPU request is no longer waiting. Gated by reset_n
  // so the output stays low while reset is held.
  assign cpu_wait = reset_n & cpu_pending & ~cpu_ack;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_cnt     <= 2'd0;
      owner_cpu   <= 1'b0;
      last_cpu    <= 1'b1;
      starve_cnt  <= 6'd0;
      vid_rd_ack  <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_data    <= 8'h00;
      cpu_rd_data <= 8'h00;
      mem_addr    <= 13'h0000;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'h00;
    end else begin
      vid_rd_ack <= 1'b0;
      cpu_ack    <= 1'b0;
      mem_wr_en  <= 1'b0;

      // Saturating count of cycles the CPU sits pending behind video DMA.
      if (!cpu_pending || grant_cpu || cpu_active) begin
        starve_cnt <= 6'd0;
      end else if (vid_dma_req && (starve_cnt != 6'h3F)) begin
        starve_cnt <= starve_cnt + 6'd1;
      end

      case (state)
        IDLE: begin
          if (grant_cpu) begin
            mem_addr  <= cpu_addr;
            owner_cpu <= 1'b1;
            last_cpu  <= 1'b1;
            if (cpu_wr_req) begin
              mem_wr_data <= cpu_wr_data;
              mem_wr_en   <= 1'b1;
              state       <= CPU_WR;
            end else begin
              state <= CPU_RD;
            end
          end else if (grant_vid) begin
            mem_addr  <= vid_addr;
            owner_cpu <= 1'b0;
            last_cpu  <= 1'b0;
            state     <= VID_RD;
          end
        end
        VID_RD, CPU_RD: begin
          lat_cnt <= 2'd0;
          state   <= WAIT;
        end
        CPU_WR: begin
          cpu_ack <= 1'b1;
          state   <= DONE;
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            if (owner_cpu) begin
              cpu_rd_data <= mem_rd_data;
              cpu_ack     <= 1'b1;
            end else begin
              vid_data   <= mem_rd_data;
              vid_rd_ack <= 1'b1;
            end
            state <= DONE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        // The requester drops its request on the ack edge, so DONE goes back
        // to IDLE without looking at the request lines.
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
